// File: rtl/cellrv32_package.sv
// Shared types and constants for the CPU co-processor dispatch slice.
package cellrv32_package;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2,
    S_RESP = 2'd3
  } cp_disp_state_t;

  localparam int cp_sel_muldiv_c   = 0;
  localparam int cp_sel_shifter_c  = 1;
  localparam int cp_sel_bitmanip_c = 2;
  localparam int cp_sel_custom_c   = 3;

endpackage

// File: rtl/cellrv32_cpu_cp_watchdog.sv
// Cycle counter for a co-processor operation; flags expiry on the last allowed wait cycle.
module cellrv32_cpu_cp_watchdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr_i,
  input  logic cnt_en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (cnt_en_i && (cnt_q != LIMIT)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = cnt_en_i & (cnt_q == LIMIT);

endmodule

// File: rtl/cellrv32_cpu_cp_dispatch.sv
// Issue/collect stage between execute control and the co-processors.
// Optional watchdog enabled by defining CELLRV32_CP_TIMEOUT_EN.
module cellrv32_cpu_cp_dispatch
  import cellrv32_package::*;
#(
  parameter int XLEN        = 32,
  parameter int NUM_CP      = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   req_i,
  input  logic [NUM_CP-1:0]      sel_i,
  input  logic                   trap_i,
  output logic [NUM_CP-1:0]      cp_start_o,
  input  logic [NUM_CP-1:0]      cp_valid_i,
  input  logic [NUM_CP*XLEN-1:0] cp_res_i,
  output logic [XLEN-1:0]        res_o,
  output logic                   done_o,
  output logic                   stall_o,
  output logic                   illegal_o,
  output logic                   timeout_o
);

  if (NUM_CP < 1 || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("cellrv32_cpu_cp_dispatch: NUM_CP must be >=1 and TIMEOUT_CYC >=2");
  end

  cp_disp_state_t    state_q;
  logic [NUM_CP-1:0] sel_q;
  logic [XLEN-1:0]   res_q;
  logic [XLEN-1:0]   res_mux;
  logic              abort_q;
  logic              illegal_q;
  logic              tmo_q;
  logic              accept;
  logic              hit;
  logic              tmo_exp;

  assign accept     = (state_q == S_IDLE) & req_i & $onehot(sel_i);
  assign cp_start_o = sel_i & {NUM_CP{accept}};
  assign hit        = |(cp_valid_i & sel_q);

  // Idle units drive zero, so masking by the latched select and OR-ing is a full mux.
  always_comb begin
    res_mux = '0;
    for (int k = 0; k < NUM_CP; k++) begin
      if (sel_q[k]) res_mux = res_mux | cp_res_i[k*XLEN +: XLEN];
    end
  end

`ifdef CELLRV32_CP_TIMEOUT_EN
  cellrv32_cpu_cp_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .clr_i     (accept),
    .cnt_en_i  (state_q == S_WAIT),
    .expired_o (tmo_exp)
  );
`else
  assign tmo_exp = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      sel_q     <= '0;
      res_q     <= '0;
      abort_q   <= 1'b0;
      illegal_q <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            sel_q   <= sel_i;
            abort_q <= 1'b0;
            tmo_q   <= 1'b0;
            state_q <= S_WAIT;
          end else if (req_i) begin
            illegal_q <= 1'b1;
          end
        end
        // A trapped op keeps waiting: the unit still finishes with a valid.
        S_WAIT: begin
          if (trap_i) abort_q <= 1'b1;
          if (hit) begin
            state_q <= S_CAPT;
          end else if (tmo_exp) begin
            res_q   <= '0;
            tmo_q   <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_CAPT: begin
          res_q   <= abort_q ? '0 : res_mux;
          if (trap_i) abort_q <= 1'b1;
          state_q <= S_RESP;
        end
        S_RESP: begin
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A watchdog expiry always reports, even for an aborted op.
  assign done_o    = (state_q == S_RESP) & (~abort_q | tmo_q);
  assign res_o     = done_o ? res_q : '0;
  assign timeout_o = (state_q == S_RESP) & tmo_q;
  assign illegal_o = illegal_q;
  assign stall_o   = accept | (state_q == S_WAIT) | (state_q == S_CAPT);

endmodule

// File: tb/tb_cellrv32_cpu_cp_dispatch.sv
// Directed bench for the co-processor dispatch stage; also covers the watchdog build.
module tb_cellrv32_cpu_cp_dispatch;

  localparam int XLEN = 32;
  localparam int NCP  = 4;

  logic            clk_i = 1'b0;
  logic            rstn_i = 1'b0;
  logic            req_i = 1'b0;
  logic [NCP-1:0]  sel_i = '0;
  logic            trap_i = 1'b0;
  logic [NCP-1:0]  cp_start_o;
  logic [NCP-1:0]  cp_valid_i = '0;
  logic [NCP*XLEN-1:0] cp_res_i = '0;
  logic [XLEN-1:0] res_o;
  logic            done_o, stall_o, illegal_o, timeout_o;

  int n_chk = 0;
  int n_fail = 0;
  int done_seen = 0;
  int start_seen = 0;

  always #5 clk_i = ~clk_i;

  cellrv32_cpu_cp_dispatch #(
    .XLEN        (XLEN),
    .NUM_CP      (NCP),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .req_i      (req_i),
    .sel_i      (sel_i),
    .trap_i     (trap_i),
    .cp_start_o (cp_start_o),
    .cp_valid_i (cp_valid_i),
    .cp_res_i   (cp_res_i),
    .res_o      (res_o),
    .done_o     (done_o),
    .stall_o    (stall_o),
    .illegal_o  (illegal_o),
    .timeout_o  (timeout_o)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Start a new cycle: step past the edge and return all inputs to idle.
  task automatic nxt();
    @(posedge clk_i); #1;
    req_i = 1'b0; sel_i = '0; trap_i = 1'b0; cp_valid_i = '0; cp_res_i = '0;
  endtask

  task automatic smp();
    @(negedge clk_i);
    if (done_o) done_seen++;
    if (|cp_start_o) start_seen++;
  endtask

  task automatic fast_op(input logic [NCP-1:0] s, input int idx, input logic [XLEN-1:0] v, input string tag);
    nxt(); req_i = 1'b1; sel_i = s; smp();
    chk({tag, "_start"}, cp_start_o, s);
    chk({tag, "_stall0"}, stall_o, 1);
    nxt(); cp_valid_i = s; smp();
    chk({tag, "_start1"}, cp_start_o, 0);
    chk({tag, "_stall1"}, stall_o, 1);
    nxt(); cp_res_i[idx*XLEN +: XLEN] = v; smp();
    chk({tag, "_stall2"}, stall_o, 1);
    chk({tag, "_done2"}, done_o, 0);
    nxt(); req_i = 1'b1; sel_i = s; smp();
    chk({tag, "_done3"}, done_o, 1);
    chk({tag, "_res3"}, res_o, v);
    chk({tag, "_stall3"}, stall_o, 0);
    chk({tag, "_resp_noacc"}, cp_start_o, 0);
    nxt(); smp();
    chk({tag, "_done4"}, done_o, 0);
    chk({tag, "_res4"}, res_o, 0);
    chk({tag, "_stall4"}, stall_o, 0);
  endtask

  task automatic bad_sel(input logic [NCP-1:0] s, input string tag);
    nxt(); req_i = 1'b1; sel_i = s; smp();
    chk({tag, "_start"}, cp_start_o, 0);
    chk({tag, "_stall"}, stall_o, 0);
    chk({tag, "_ill0"}, illegal_o, 0);
    nxt(); smp();
    chk({tag, "_ill1"}, illegal_o, 1);
    chk({tag, "_idle"}, stall_o, 0);
    nxt(); smp();
    chk({tag, "_ill2"}, illegal_o, 0);
  endtask

  initial begin
    #2;
    chk("rst_start", cp_start_o, 0);
    chk("rst_res", res_o, 0);
    chk("rst_flags", {done_o, stall_o, illegal_o, timeout_o}, 0);
    @(negedge clk_i); rstn_i = 1'b1;

    // Fast multiplier on unit 0; a req during S_RESP must be ignored.
    fast_op(4'b0001, 0, 32'd42, "fmul");

`ifndef CELLRV32_CP_TIMEOUT_EN
    // Serial divider: valid 32 cycles after the request.
    nxt(); req_i = 1'b1; sel_i = 4'b0001; smp();
    chk("div_start", cp_start_o, 4'b0001);
    start_seen = 0; done_seen = 0;
    for (int i = 1; i < 32; i++) begin nxt(); smp(); end
    nxt(); cp_valid_i = 4'b0001; smp();
    nxt(); cp_res_i[31:0] = 32'hFFFFFFFD; smp();
    chk("div_done_early", done_seen, 0);
    nxt(); smp();
    chk("div_done", done_o, 1);
    chk("div_res", res_o, 32'hFFFFFFFD);
    chk("div_extra_start", start_seen, 0);
    nxt(); smp();
`endif

    bad_sel(4'b0011, "ill_multi");
    bad_sel(4'b0000, "ill_zero");

    // Trap while waiting: op drains silently.
    done_seen = 0;
    nxt(); req_i = 1'b1; sel_i = 4'b0001; smp();
    nxt(); trap_i = 1'b1; smp();
    for (int i = 0; i < 3; i++) begin nxt(); smp(); end
    nxt(); cp_valid_i = 4'b0001; smp();
    nxt(); cp_res_i[31:0] = 32'h1234; smp();
    chk("trap_stall_capt", stall_o, 1);
    nxt(); smp();
    chk("trap_res", res_o, 0);
    chk("trap_stall_resp", stall_o, 0);
    nxt(); smp();
    chk("trap_no_done", done_seen, 0);
    chk("trap_idle", stall_o, 0);
    fast_op(4'b0001, 0, 32'd7, "post_trap");

    // Cross-talk: unit 2 valid while unit 1 is selected.
    nxt(); req_i = 1'b1; sel_i = 4'b0010; smp();
    nxt(); cp_valid_i = 4'b0100; smp();
    nxt(); cp_res_i[2*XLEN +: XLEN] = 32'hDEAD; smp();
    chk("xt_stall", stall_o, 1);
    nxt(); smp();
    chk("xt_nodone", done_o, 0);
    chk("xt_still_wait", stall_o, 1);
    nxt(); cp_valid_i = 4'b0010; smp();
    nxt(); cp_res_i[1*XLEN +: XLEN] = 32'h5; smp();
    nxt(); smp();
    chk("xt_done", done_o, 1);
    chk("xt_res", res_o, 32'h5);
    nxt(); smp();

`ifdef CELLRV32_CP_TIMEOUT_EN
    // Never-valid unit: watchdog fires 9 cycles after the request.
    nxt(); req_i = 1'b1; sel_i = 4'b0010; smp();
    for (int i = 1; i < 9; i++) begin nxt(); smp(); end
    chk("tmo_early", {done_o, timeout_o}, 0);
    chk("tmo_stall8", stall_o, 1);
    nxt(); smp();
    chk("tmo_done", done_o, 1);
    chk("tmo_flag", timeout_o, 1);
    chk("tmo_res", res_o, 0);
    nxt(); smp();
    chk("tmo_clear", {done_o, timeout_o, stall_o}, 0);
    // Valid in the expiry cycle beats the watchdog.
    nxt(); req_i = 1'b1; sel_i = 4'b0010; smp();
    for (int i = 1; i < 8; i++) begin nxt(); smp(); end
    nxt(); cp_valid_i = 4'b0010; smp();
    nxt(); cp_res_i[1*XLEN +: XLEN] = 32'd99; smp();
    chk("race_no_tmo", {done_o, timeout_o}, 0);
    nxt(); smp();
    chk("race_done", done_o, 1);
    chk("race_res", res_o, 32'd99);
    chk("race_tmo", timeout_o, 0);
    nxt(); smp();
`endif

    // Hung unit, then reset mid-operation.
    done_seen = 0;
    nxt(); req_i = 1'b1; sel_i = 4'b1000; smp();
`ifdef CELLRV32_CP_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin nxt(); smp(); end
`else
    for (int i = 0; i < 100; i++) begin nxt(); smp(); end
`endif
    chk("hang_stall", stall_o, 1);
    chk("hang_no_done", done_seen, 0);
    @(posedge clk_i); #1; rstn_i = 1'b0; #1;
    chk("rst_mid_stall", stall_o, 0);
    chk("rst_mid_out", {done_o, timeout_o, illegal_o, cp_start_o}, 0);
    @(negedge clk_i); rstn_i = 1'b1;
    nxt(); cp_valid_i = 4'b1000; smp();
    nxt(); cp_res_i[3*XLEN +: XLEN] = 32'hBEEF; smp();
    for (int i = 0; i < 3; i++) begin nxt(); smp(); end
    chk("rst_no_spurious", done_seen, 0);
    chk("rst_idle", stall_o, 0);
    fast_op(4'b1000, 3, 32'hCAFE_0001, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
